regfile_wb_arbiter: RTL and testbench

- Sequences the single write port of nbit_register_file between two writeback sources:
  - the fixed-latency ALU pipeline (source A, cannot stall);
  - the multi-cycle mul/div unit (source B, backpressurable).
- Holds a 1-entry skid buffer for B and keeps a busy-bit scoreboard of pending long-latency destinations.
- Stalls issue on RAW/WAW hazards, pending-limit overflow and B starvation.
- Sits between the decode/issue stage, the writeback stage and the register file.

---
 rtl/regfile_ctrl_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and the writeback-source tag for the register-file write arbiter.
package regfile_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int SEL_WIDTH_DEF  = 5;

    // Identifies which source produced the write held in the output register.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_A    = 2'd1,
        WB_B    = 2'd2
    } wb_src_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations plus a count of busy registers.
module regfile_scoreboard #(
    parameter int SEL_WIDTH   = 5,
    parameter int MAX_PENDING = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [SEL_WIDTH-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [SEL_WIDTH-1:0] clr_addr,
    input  logic [SEL_WIDTH-1:0] src1,
    input  logic [SEL_WIDTH-1:0] src2,
    input  logic [SEL_WIDTH-1:0] dest,
    output logic                 hazard_src1,
    output logic                 hazard_src2,
    output logic                 hazard_dest,
    output logic                 full,
    output logic [SEL_WIDTH:0]   count
);

    localparam int NREGS = 2 ** SEL_WIDTH;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             set_eff;
    logic             clr_eff;

    // Register 0 never becomes busy; a clear only counts if the bit was actually set.
    assign set_eff = set_en && (set_addr != '0);
    assign clr_eff = clr_en && busy[clr_addr];

    always_comb begin
        busy_next = busy;
        if (clr_eff) busy_next[clr_addr] = 1'b0;
        if (set_eff) busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy <= busy_next;
            case ({set_eff, clr_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign hazard_src1 = busy[src1];
    assign hazard_src2 = busy[src2];
    assign hazard_dest = busy[dest];
    assign full        = (count == (SEL_WIDTH + 1)'(MAX_PENDING));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the ALU (A) and the mul/div unit (B),
// buffering one B write and stalling issue on hazards, pending overflow and B starvation.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SEL_WIDTH    = SEL_WIDTH_DEF,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic                  issue_long,
    input  logic [SEL_WIDTH-1:0]  issue_dest,
    input  logic [SEL_WIDTH-1:0]  issue_src1,
    input  logic [SEL_WIDTH-1:0]  issue_src2,
    output logic                  issue_stall,
    input  logic                  a_valid,
    input  logic [SEL_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    input  logic [SEL_WIDTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  RegWrite,
    output logic [SEL_WIDTH-1:0]  write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [SEL_WIDTH:0]    pending_count
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                  buf_full;
    logic [SEL_WIDTH-1:0]  buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  b_accept;
    logic                  buf_drain;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  starve_forced;
    wb_src_t               sel_src;
    wb_src_t               wb_src;
    logic [SEL_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  b_commit;
    logic                  hz_src1, hz_src2, hz_dest, sb_full;
    logic                  issue_set;

    // B handshake: a write transfers on a rising edge where b_valid && b_ready;
    // b_ready is simply "buffer empty", so a fill and a drain never share a cycle.
    assign b_ready   = !buf_full;
    assign b_accept  = b_valid && !buf_full;
    assign buf_drain = buf_full && !a_valid;

    always_comb begin
        sel_src  = WB_NONE;
        sel_addr = '0;
        sel_data = '0;
        if (a_valid) begin
            sel_src  = WB_A;
            sel_addr = a_addr;
            sel_data = a_data;
        end else if (buf_full) begin
            sel_src  = WB_B;
            sel_addr = buf_addr;
            sel_data = buf_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (b_accept) begin
            buf_full <= 1'b1;
            buf_addr <= b_addr;
            buf_data <= b_data;
        end else if (buf_drain) begin
            buf_full <= 1'b0;
        end
    end

    assign starve_forced = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (buf_drain) begin
            starve_cnt <= '0;
        end else if (buf_full && a_valid && !starve_forced) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to register 0 are dropped here; the buffer still drains above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            wb_src        <= WB_NONE;
        end else begin
            RegWrite      <= (sel_src != WB_NONE) && (sel_addr != '0);
            write_address <= sel_addr;
            write_data    <= sel_data;
            wb_src        <= (sel_addr != '0) ? sel_src : WB_NONE;
        end
    end

    // The busy bit clears on the same edge the register file commits the B write.
    assign b_commit = RegWrite && (wb_src == WB_B);

    assign issue_stall = issue_valid &&
                         (hz_src1 || hz_src2 || (issue_writes && hz_dest) ||
                          (issue_long && sb_full) || starve_forced);

    assign issue_set = issue_valid && !issue_stall && issue_writes && issue_long;

    regfile_scoreboard #(
        .SEL_WIDTH   (SEL_WIDTH),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (issue_set),
        .set_addr    (issue_dest),
        .clr_en      (b_commit),
        .clr_addr    (write_address),
        .src1        (issue_src1),
        .src2        (issue_src2),
        .dest        (issue_dest),
        .hazard_src1 (hz_src1),
        .hazard_src2 (hz_src2),
        .hazard_dest (hz_dest),
        .full        (sb_full),
        .count       (pending_count)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk;
    logic          reset;
    logic          issue_valid, issue_writes, issue_long;
    logic [SW-1:0] issue_dest, issue_src1, issue_src2;
    logic          issue_stall;
    logic          a_valid;
    logic [SW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic [SW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          RegWrite;
    logic [SW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [SW:0]   pending_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH   (DW),
        .SEL_WIDTH    (SW),
        .MAX_PENDING  (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_long    (issue_long),
        .issue_dest    (issue_dest),
        .issue_src1    (issue_src1),
        .issue_src2    (issue_src2),
        .issue_stall   (issue_stall),
        .a_valid       (a_valid),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .RegWrite      (RegWrite),
        .write_address (write_address),
        .write_data    (write_data),
        .pending_count (pending_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 0; issue_writes = 0; issue_long = 0;
        issue_dest = '0; issue_src1 = '0; issue_src2 = '0;
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_waddr", write_address, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_bready", b_ready, 1);
        issue_valid = 1;
        #1 chk("rst_stall", issue_stall, 0);
        issue_valid = 0;
        tick();

        // Reset arriving mid-cycle with the buffer full and one long op pending.
        a_valid = 1; a_addr = 7; a_data = 1;
        b_valid = 1; b_addr = 5; b_data = 55;
        issue_valid = 1; issue_long = 1; issue_writes = 1; issue_dest = 9;
        tick();
        b_valid = 0; issue_valid = 0; issue_long = 0; issue_writes = 0; issue_dest = 0;
        #1;
        chk("pre_rst_bready", b_ready, 0);
        chk("pre_rst_regwrite", RegWrite, 1);
        chk("pre_rst_waddr", write_address, 7);
        chk("pre_rst_pending", pending_count, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_bready", b_ready, 1);
        chk("mid_rst_regwrite", RegWrite, 0);
        chk("mid_rst_waddr", write_address, 0);
        chk("mid_rst_wdata", write_data, 0);
        chk("mid_rst_pending", pending_count, 0);
        a_valid = 0;
        #1 reset = 1'b0;
        tick();
        chk("rst_drop_b_regwrite", RegWrite, 0);
        chk("rst_drop_b_bready", b_ready, 1);

        // A-only stream.
        a_valid = 1; a_addr = 30; a_data = 935;
        tick();
        a_addr = 29; a_data = 34;
        #1;
        chk("a1_regwrite", RegWrite, 1);
        chk("a1_waddr", write_address, 30);
        chk("a1_wdata", write_data, 935);
        tick();
        a_addr = 0; a_data = 5;
        #1;
        chk("a2_regwrite", RegWrite, 1);
        chk("a2_waddr", write_address, 29);
        chk("a2_wdata", write_data, 34);
        tick();
        a_valid = 0;
        #1 chk("a_zero_regwrite", RegWrite, 0);
        tick();

        // RAW on a long op returning through B.
        issue_valid = 1; issue_long = 1; issue_writes = 1; issue_dest = 10;
        #1 chk("raw_issue_long", issue_stall, 0);
        tick();
        issue_long = 0; issue_dest = 11; issue_src1 = 10;
        b_valid = 1; b_addr = 10; b_data = 77;
        #1;
        chk("raw_stall_busy", issue_stall, 1);
        chk("raw_pending1", pending_count, 1);
        chk("raw_bready", b_ready, 1);
        tick();
        b_valid = 0;
        #1;
        chk("raw_stall_buffered", issue_stall, 1);
        chk("raw_bready_full", b_ready, 0);
        tick();
        chk("raw_b_regwrite", RegWrite, 1);
        chk("raw_b_waddr", write_address, 10);
        chk("raw_b_wdata", write_data, 77);
        chk("raw_stall_commit", issue_stall, 1);
        chk("raw_pending_commit", pending_count, 1);
        tick();
        chk("raw_stall_release", issue_stall, 0);
        chk("raw_pending0", pending_count, 0);
        issue_valid = 0; issue_writes = 0; issue_dest = 0; issue_src1 = 0;
        tick();

        // A holds the port for 3 cycles while B waits in the buffer.
        b_valid = 1; b_addr = 12; b_data = 18;
        tick();
        b_valid = 0;
        a_valid = 1; a_addr = 20; a_data = 3;
        #1 chk("conf_bready_c1", b_ready, 0);
        tick();
        chk("conf_bready_c2", b_ready, 0);
        chk("conf_a_waddr_c2", write_address, 20);
        tick();
        chk("conf_bready_c3", b_ready, 0);
        tick();
        a_valid = 0;
        #1;
        chk("conf_bready_c4", b_ready, 0);
        chk("conf_a_waddr_c4", write_address, 20);
        tick();
        chk("conf_b_regwrite", RegWrite, 1);
        chk("conf_b_waddr", write_address, 12);
        chk("conf_b_wdata", write_data, 18);
        chk("conf_bready_c5", b_ready, 1);
        tick();

        // Starvation: A never lets the buffer drain.
        b_valid = 1; b_addr = 13; b_data = 19;
        a_valid = 1; a_addr = 21; a_data = 4;
        issue_valid = 1;
        #1 chk("starve_c0", issue_stall, 0);
        tick();
        b_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            #1 chk($sformatf("starve_pre_c%0d", k), issue_stall, 0);
            tick();
        end
        chk("starve_forced_c9", issue_stall, 1);
        tick();
        chk("starve_forced_c10", issue_stall, 1);
        a_valid = 0;
        #1 chk("starve_drain_cycle", issue_stall, 1);
        tick();
        chk("starve_released", issue_stall, 0);
        chk("starve_b_regwrite", RegWrite, 1);
        chk("starve_b_waddr", write_address, 13);
        chk("starve_b_wdata", write_data, 19);
        issue_valid = 0;
        tick();

        // A buffered B write to register 0 is consumed but never written.
        b_valid = 1; b_addr = 0; b_data = 99;
        tick();
        b_valid = 0;
        #1 chk("bzero_bready_full", b_ready, 0);
        tick();
        chk("bzero_bready_empty", b_ready, 1);
        chk("bzero_regwrite", RegWrite, 0);
        tick();

        // Pending limit, WAW and a non-dependent short op.
        issue_valid = 1; issue_long = 1; issue_writes = 1;
        for (int d = 1; d <= 4; d++) begin
            issue_dest = SW'(d);
            #1 chk($sformatf("lim_issue_%0d", d), issue_stall, 0);
            tick();
        end
        issue_dest = 5;
        #1;
        chk("lim_pending4", pending_count, 4);
        chk("lim_fifth_stall", issue_stall, 1);
        issue_long = 0; issue_dest = 6; issue_src1 = 7; issue_src2 = 8;
        #1 chk("lim_short_ok", issue_stall, 0);
        issue_dest = 3;
        #1 chk("lim_waw_stall", issue_stall, 1);
        issue_valid = 0; issue_writes = 0; issue_dest = 0; issue_src1 = 0; issue_src2 = 0;

        b_valid = 1; b_addr = 1; b_data = 100;
        tick();
        b_valid = 0;
        tick();
        chk("ret1_regwrite", RegWrite, 1);
        chk("ret1_waddr", write_address, 1);
        tick();
        chk("ret1_pending3", pending_count, 3);

        // Set of reg 5 on the same edge that clears reg 2.
        b_valid = 1; b_addr = 2; b_data = 200;
        tick();
        b_valid = 0;
        tick();
        issue_valid = 1; issue_long = 1; issue_writes = 1; issue_dest = 5;
        #1;
        chk("simul_issue_ok", issue_stall, 0);
        chk("simul_b_waddr", write_address, 2);
        tick();
        issue_valid = 0; issue_long = 0; issue_writes = 0; issue_dest = 0;
        #1 chk("simul_pending3", pending_count, 3);
        issue_valid = 1; issue_src1 = 2;
        #1 chk("simul_reg2_free", issue_stall, 0);
        issue_src1 = 5;
        #1 chk("simul_reg5_busy", issue_stall, 1);
        issue_valid = 0; issue_src1 = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
